data_path_p: RTL and testbench
==============================

# data_path_p

Parametrised successor to the EDULENT 8-bit data path. It holds PC, IR, SP, MA, MD, A, AP, R, IN, OUT and the C/Z flags, and executes one register-transfer command per cycle from the control unit. It adds generic DATA_W/ADDR_W widths, an explicit ALU opcode with a true carry, conditional-jump selection, and a req/ack memory handshake with a busy stall. It sits between the control unit and the memory/IO subsystem.

## Interface
- DATA_W, 8: width of A, AP, R, MD, IR, IN, OUT and the ALU. Must be ≥ ADDR_W.
- ADDR_W, 8: width of PC, SP, MA and the memory address.
- SP_INIT, {ADDR_W{1'b1}}: SP value after reset. The stack grows down.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports i_clk, i_rstn.
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_transfer_cmd  in  4  register-transfer command; 0 = nop
- i_alu_calculate  in  1  latch ALU result into R and update C/Z
- i_alu_op  in  3  0 ADD, 1 SUB, 2 NOT, 3 OR, 4 AND, 5 XOR, 6 SHR, 7 SHL
- i_alu_dst  in  1  0 selects A, 1 selects AP, as ALU operand X and as target of commands 5/8/A
- i_jmp_cond  in  2  condition for command B: 00 always, 01 Z, 10 C, 11 !Z
- i_inc_pc  in  1  PC += 1
- i_inc_dec_sp  in  2  01 increments SP, 10 decrements SP, 00/11 hold
- i_reset_ir  in  1  clear IR
- i_in  in  DATA_W  input port
- o_out  out  DATA_W  OUT register
- o_IR  out  DATA_W  IR register
- o_flags  out  2  {C, Z}
- o_busy  out  1  memory transaction outstanding
- o_sp_fault  out  1  sticky stack overflow/underflow flag
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req is high
- o_mem_addr  out  ADDR_W  MA
- o_mem_wdata  out  DATA_W  MD captured at write start
- i_mem_rdata  in  DATA_W  read data, valid with ack
- i_mem_ack  in  1  completes the current transaction

## Operation
- Reset values:
  - All registers, R, flags, OUT, IR, MA and MD are 0; SP = SP_INIT.
  - o_mem_req, o_mem_we, o_mem_wdata, o_busy and o_sp_fault are 0.
  - The FSM is in IDLE.
- IN samples i_in every cycle.
- Commands:
  - 1: MA←PC
  - 2: start a read
  - 3: IR←MD
  - 4: MA←MD[ADDR_W-1:0]
  - 5: X←MD
  - 6: MA←AP[ADDR_W-1:0]
  - 7: MA←SP
  - 8: MD←X
  - 9: start a write
  - A: X←R
  - B: PC←MD[ADDR_W-1:0] if i_jmp_cond holds
  - C: A←IN
  - D: OUT←A
  - E: PC←AP[ADDR_W-1:0]
  - F: MD←zero-extended PC
- ALU operands and result width:
  - X is A or AP, selected by i_alu_dst. Y is MD.
  - The result is computed on DATA_W+1 bits. R takes the low DATA_W bits.
- ALU carry rules:
  - ADD: C = bit DATA_W of the sum.
  - SUB: C = 1 when X < Y (borrow).
  - NOT, OR, AND, XOR: C = 0.
  - SHR: C = X[0], and the result shifts in 0 at the top.
  - SHL: C = X[DATA_W-1], and the result shifts in 0 at the bottom.
- ALU zero flag: Z = (R == 0).
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE, command 2: go to RD_WAIT with req = 1, we = 0.
  - IDLE, command 9: go to WR_WAIT with req = 1, we = 1, wdata ← MD.
  - RD_WAIT with ack: MD ← i_mem_rdata, req = 0, return to IDLE.
  - WR_WAIT with ack: req = 0, return to IDLE.
  - Without ack, the state and all outputs hold.
- While o_busy = 1, these inputs are ignored: i_transfer_cmd, i_inc_pc, i_inc_dec_sp, i_alu_calculate, i_reset_ir.
- i_mem_ack in IDLE is ignored.
- Same-cycle priorities:
  - i_reset_ir overrides command 3.
  - i_inc_pc overrides commands B and E.
  - The ALU latch and command A in the same cycle: A/AP takes the old R.

## Timing
- Register transfers, the ALU latch, PC/SP updates and flag updates take effect at the next clock edge (1-cycle latency).
- Memory transaction timing:
  - A command issued in cycle N drives o_mem_req = o_busy = 1 from cycle N+1.
  - An ack in cycle K ends the transaction; o_busy = 0 and MD is valid in cycle K+1.
  - Minimum transaction is 2 cycles (ack in N+1).
- o_busy is a decode of state ≠ IDLE; all other outputs are registered.
- If reset is asserted mid-transaction, req drops asynchronously and the FSM returns to IDLE. A late ack after reset is ignored.

## Configuration
- DATA_PATH_SP_GUARD_EN defined:
  - An SP increment at all-ones or a decrement at 0 is suppressed (SP holds).
  - The same cycle sets o_sp_fault, which stays set until reset.
- DATA_PATH_SP_GUARD_EN undefined:
  - SP wraps modulo 2^ADDR_W.
  - o_sp_fault is tied 0.

## Test plan
- Reset, then MA←PC, read with ack after 3 wait cycles returning 0x3C, then IR←MD → o_busy high for 4 cycles, MD = 0x3C, o_IR = 0x3C.
- A = 0xF0, MD = 0x20, ADD with calculate, then command A → A = 0x10, C = 1, Z = 0.
- A = 0x05, MD = 0x05, SUB → R = 0, Z = 1, C = 0. Then A = 0x03, SUB → R = 0xFE, C = 1.
- MD = 0x40, Z = 0, command B with i_jmp_cond = 01 → PC unchanged. With i_jmp_cond = 11 → PC = 0x40. With i_inc_pc also asserted → PC = PC+1.
- Write MD = 0x77 and hold ack low for 5 cycles, pulsing i_inc_pc → PC unchanged, o_mem_wdata = 0x77. Reset mid-wait → o_mem_req = 0 immediately.
- SP_INIT = 0xFF with one increment: with DATA_PATH_SP_GUARD_EN → SP = 0xFF, o_sp_fault = 1. Without it → SP = 0x00, o_sp_fault = 0.

Source files
------------

// File: rtl/data_path_p.sv
// data_path_p: parametrised register-transfer data path.
// Holds PC, IR, SP, MA, MD, A, AP, R, IN, OUT and the C/Z flags. Executes one
// register-transfer command per cycle and runs a req/ack memory handshake.
//
// Build option: define DATA_PATH_SP_GUARD_EN to enable the stack guard.
// With the guard, SP saturates at its limits and a sticky o_sp_fault is set.
// Without the guard, SP wraps and o_sp_fault is tied 0.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_transfer_cmd       register-transfer command (0 = nop)
//   i_alu_calculate      latch ALU result into R and update C/Z
//   i_alu_op, i_alu_dst  ALU opcode; operand X / transfer target (A or AP)
//   i_jmp_cond           condition for the conditional jump
//   i_inc_pc             PC increment
//   i_inc_dec_sp         SP increment (01) or decrement (10)
//   i_reset_ir           clear IR
//   i_in / o_out         input port / OUT register
//   o_IR, o_flags        IR register, {C, Z}
//   o_busy, o_sp_fault   transaction outstanding, sticky stack fault
//   o_mem_*, i_mem_*     memory request channel
module data_path_p #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_alu_calculate,
  input  logic [2:0]        i_alu_op,
  input  logic              i_alu_dst,
  input  logic [1:0]        i_jmp_cond,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_reset_ir,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] o_IR,
  output logic [1:0]        o_flags,
  output logic              o_busy,
  output logic              o_sp_fault,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} mem_st_e;

  mem_st_e           state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d;
  logic [DATA_W-1:0] ir_q, ir_d, md_q, md_d, a_q, a_d, ap_q, ap_d, r_q, r_d;
  logic [DATA_W-1:0] in_q, out_q, out_d, wdata_q, wdata_d;
  logic              c_q, c_d, z_q, z_d, req_q, req_d, we_q, we_d;

  // Control inputs are masked while a memory transaction is outstanding.
  logic              idle;
  logic [3:0]        cmd;
  logic              inc_pc, alu_calc, reset_ir;
  logic [1:0]        inc_dec_sp;

  assign idle       = (state_q == StIdle);
  assign cmd        = idle ? i_transfer_cmd : 4'h0;
  assign inc_pc     = idle & i_inc_pc;
  assign alu_calc   = idle & i_alu_calculate;
  assign reset_ir   = idle & i_reset_ir;
  assign inc_dec_sp = idle ? i_inc_dec_sp : 2'b00;

  // ALU on DATA_W+1 bits; the top bit carries the ADD carry / SUB borrow.
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W:0]   alu_res;
  logic              alu_c;

  assign alu_x = i_alu_dst ? ap_q : a_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (i_alu_op)
      3'd0: begin
        alu_res = {1'b0, alu_x} + {1'b0, md_q};
        alu_c   = alu_res[DATA_W];
      end
      3'd1: begin
        alu_res = {1'b0, alu_x} - {1'b0, md_q};
        alu_c   = alu_res[DATA_W];
      end
      3'd2: alu_res = {1'b0, ~alu_x};
      3'd3: alu_res = {1'b0, alu_x | md_q};
      3'd4: alu_res = {1'b0, alu_x & md_q};
      3'd5: alu_res = {1'b0, alu_x ^ md_q};
      3'd6: begin
        alu_res = {2'b00, alu_x[DATA_W-1:1]};
        alu_c   = alu_x[0];
      end
      3'd7: begin
        alu_res = {alu_x, 1'b0};
        alu_c   = alu_x[DATA_W-1];
      end
    endcase
  end

  logic jmp_ok;
  always_comb begin
    unique case (i_jmp_cond)
      2'b00: jmp_ok = 1'b1;
      2'b01: jmp_ok = z_q;
      2'b10: jmp_ok = c_q;
      2'b11: jmp_ok = ~z_q;
    endcase
  end

  // Register transfers, ALU latch and memory FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ma_d    = ma_q;
    ir_d    = ir_q;
    md_d    = md_q;
    a_d     = a_q;
    ap_d    = ap_q;
    r_d     = r_q;
    out_d   = out_q;
    c_d     = c_q;
    z_d     = z_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    if (inc_pc) pc_d = pc_q + ADDR_W'(1);

    case (cmd)
      4'h1: ma_d = pc_q;
      4'h3: ir_d = md_q;
      4'h4: ma_d = md_q[ADDR_W-1:0];
      4'h5: if (i_alu_dst) ap_d = md_q; else a_d = md_q;
      4'h6: ma_d = ap_q[ADDR_W-1:0];
      4'h7: ma_d = sp_q;
      4'h8: md_d = alu_x;
      // Reads the current R, so a same-cycle ALU latch is not seen here.
      4'hA: if (i_alu_dst) ap_d = r_q; else a_d = r_q;
      4'hB: if (jmp_ok && !inc_pc) pc_d = md_q[ADDR_W-1:0];
      4'hC: a_d = in_q;
      4'hD: out_d = a_q;
      4'hE: if (!inc_pc) pc_d = ap_q[ADDR_W-1:0];
      4'hF: md_d = DATA_W'(pc_q);
      default: ;
    endcase

    if (reset_ir) ir_d = '0;

    if (alu_calc) begin
      r_d = alu_res[DATA_W-1:0];
      c_d = alu_c;
      z_d = (alu_res[DATA_W-1:0] == '0);
    end

    unique case (state_q)
      StIdle: begin
        if (i_transfer_cmd == 4'h2) begin
          state_d = StRdWait;
          req_d   = 1'b1;
          we_d    = 1'b0;
        end else if (i_transfer_cmd == 4'h9) begin
          state_d = StWrWait;
          req_d   = 1'b1;
          we_d    = 1'b1;
          wdata_d = md_q;
        end
      end
      StRdWait: begin
        if (i_mem_ack) begin
          md_d    = i_mem_rdata;
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (i_mem_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stack pointer with optional saturation guard.
`ifdef DATA_PATH_SP_GUARD_EN
  logic sp_fault_q, sp_fault_d;

  always_comb begin
    sp_d       = sp_q;
    sp_fault_d = sp_fault_q;
    if (inc_dec_sp == 2'b01) begin
      if (sp_q == '1) sp_fault_d = 1'b1;
      else            sp_d       = sp_q + ADDR_W'(1);
    end else if (inc_dec_sp == 2'b10) begin
      if (sp_q == '0) sp_fault_d = 1'b1;
      else            sp_d       = sp_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sp_fault_q <= 1'b0;
    else         sp_fault_q <= sp_fault_d;
  end

  assign o_sp_fault = sp_fault_q;
`else
  always_comb begin
    sp_d = sp_q;
    if (inc_dec_sp == 2'b01)      sp_d = sp_q + ADDR_W'(1);
    else if (inc_dec_sp == 2'b10) sp_d = sp_q - ADDR_W'(1);
  end

  assign o_sp_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= SP_INIT;
      ma_q    <= '0;
      ir_q    <= '0;
      md_q    <= '0;
      a_q     <= '0;
      ap_q    <= '0;
      r_q     <= '0;
      in_q    <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ma_q    <= ma_d;
      ir_q    <= ir_d;
      md_q    <= md_d;
      a_q     <= a_d;
      ap_q    <= ap_d;
      r_q     <= r_d;
      in_q    <= i_in;
      out_q   <= out_d;
      c_q     <= c_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_out       = out_q;
  assign o_IR        = ir_q;
  assign o_flags     = {c_q, z_q};
  assign o_busy      = ~idle;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = ma_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_path_p.sv
// Directed bench for data_path_p (default 8-bit widths). Expectations are
// queued when the stimulus is applied and compared when the output is sampled.
module tb_data_path_p;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [3:0] i_transfer_cmd = '0;
  logic       i_alu_calculate = 1'b0;
  logic [2:0] i_alu_op = '0;
  logic       i_alu_dst = 1'b0;
  logic [1:0] i_jmp_cond = '0;
  logic       i_inc_pc = 1'b0;
  logic [1:0] i_inc_dec_sp = '0;
  logic       i_reset_ir = 1'b0;
  logic [7:0] i_in = '0;
  logic [7:0] o_out, o_IR, o_mem_wdata;
  logic [1:0] o_flags;
  logic       o_busy, o_sp_fault, o_mem_req, o_mem_we;
  logic [7:0] o_mem_addr;
  logic [7:0] i_mem_rdata = '0;
  logic       i_mem_ack = 1'b0;

  data_path_p #(
    .DATA_W (8),
    .ADDR_W (8),
    .SP_INIT(8'hFF)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_transfer_cmd (i_transfer_cmd),
    .i_alu_calculate(i_alu_calculate),
    .i_alu_op       (i_alu_op),
    .i_alu_dst      (i_alu_dst),
    .i_jmp_cond     (i_jmp_cond),
    .i_inc_pc       (i_inc_pc),
    .i_inc_dec_sp   (i_inc_dec_sp),
    .i_reset_ir     (i_reset_ir),
    .i_in           (i_in),
    .o_out          (o_out),
    .o_IR           (o_IR),
    .o_flags        (o_flags),
    .o_busy         (o_busy),
    .o_sp_fault     (o_sp_fault),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_ack      (i_mem_ack)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef DATA_PATH_SP_GUARD_EN
  localparam logic [7:0] SpAfterInc = 8'hFF;
  localparam logic [7:0] SpAfterDec = 8'hFE;
  localparam logic       SpFault    = 1'b1;
`else
  localparam logic [7:0] SpAfterInc = 8'h00;
  localparam logic [7:0] SpAfterDec = 8'hFF;
  localparam logic       SpFault    = 1'b0;
`endif

  // NOT, OR, AND, XOR, SHR, SHL of A=0xA5 with MD=0x3C
  logic [7:0] tbl_r [6] = '{8'h5A, 8'hBD, 8'h24, 8'h99, 8'h52, 8'h4A};
  logic       tbl_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %0h expected <queued entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_cmd(input logic [3:0] c);
    i_transfer_cmd = c;
    cyc();
    i_transfer_cmd = 4'h0;
  endtask

  task automatic load_a(input logic [7:0] v);
    i_in = v;
    cyc();
    do_cmd(4'hC);
  endtask

  task automatic mem_read(input logic [7:0] d);
    do_cmd(4'h2);
    i_mem_rdata = d;
    i_mem_ack   = 1'b1;
    cyc();
    i_mem_ack   = 1'b0;
  endtask

  task automatic alu(input logic [2:0] op);
    i_alu_op        = op;
    i_alu_calculate = 1'b1;
    cyc();
    i_alu_calculate = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int guard;

    // Reset state
    @(negedge i_clk);
    @(negedge i_clk);
    expect_val("rst_out", 0);    check_out(o_out);
    expect_val("rst_ir", 0);     check_out(o_IR);
    expect_val("rst_flags", 0);  check_out(o_flags);
    expect_val("rst_busy", 0);   check_out(o_busy);
    expect_val("rst_req", 0);    check_out(o_mem_req);
    expect_val("rst_we", 0);     check_out(o_mem_we);
    expect_val("rst_addr", 0);   check_out(o_mem_addr);
    expect_val("rst_wdata", 0);  check_out(o_mem_wdata);
    expect_val("rst_fault", 0);  check_out(o_sp_fault);
    i_rstn = 1'b1;
    cyc();
    expect_val("rst_sp", 8'hFF);
    do_cmd(4'h7);
    check_out(o_mem_addr);

    // Fetch: MA<-PC, read with three wait cycles, IR<-MD
    expect_val("fetch_ma", 8'h00);
    do_cmd(4'h1);
    check_out(o_mem_addr);
    expect_val("rd_req", 1);
    expect_val("rd_we", 0);
    do_cmd(4'h2);
    check_out(o_mem_req);
    check_out(o_mem_we);
    expect_val("rd_busy_cycles", 4);
    i_mem_rdata = 8'h3C;
    busy_cnt = 0;
    guard = 0;
    while (o_busy && guard < 20) begin
      busy_cnt++;
      guard++;
      i_mem_ack = (busy_cnt == 4);
      cyc();
    end
    i_mem_ack = 1'b0;
    check_out(busy_cnt);
    expect_val("fetch_ir", 8'h3C);
    do_cmd(4'h3);
    check_out(o_IR);
    expect_val("fetch_md", 8'h3C);
    do_cmd(4'h4);
    check_out(o_mem_addr);

    // ADD with carry out
    load_a(8'hF0);
    mem_read(8'h20);
    expect_val("add_flags", 2'b10);
    alu(3'd0);
    check_out(o_flags);
    expect_val("add_r", 8'h10);
    do_cmd(4'hA);
    do_cmd(4'hD);
    check_out(o_out);

    // SUB to zero, then SUB with borrow
    load_a(8'h05);
    mem_read(8'h05);
    expect_val("sub0_flags", 2'b01);
    alu(3'd1);
    check_out(o_flags);
    expect_val("sub0_r", 8'h00);
    do_cmd(4'hA);
    do_cmd(4'hD);
    check_out(o_out);
    load_a(8'h03);
    expect_val("subb_flags", 2'b10);
    alu(3'd1);
    check_out(o_flags);
    expect_val("subb_r", 8'hFE);
    do_cmd(4'hA);
    do_cmd(4'hD);
    check_out(o_out);

    // Conditional jumps (Z = 0 here)
    mem_read(8'h40);
    i_jmp_cond = 2'b01;
    do_cmd(4'hB);
    expect_val("jz_not_taken", 8'h00);
    do_cmd(4'h1);
    check_out(o_mem_addr);
    i_jmp_cond = 2'b11;
    do_cmd(4'hB);
    expect_val("jnz_taken", 8'h40);
    do_cmd(4'h1);
    check_out(o_mem_addr);
    i_inc_pc = 1'b1;
    do_cmd(4'hB);
    i_inc_pc = 1'b0;
    expect_val("jmp_vs_inc_pc", 8'h41);
    do_cmd(4'h1);
    check_out(o_mem_addr);

    // Logic and shift ops; R moved to AP and observed through MA
    load_a(8'hA5);
    mem_read(8'h3C);
    for (int i = 0; i < 6; i++) begin
      i_alu_dst = 1'b0;
      expect_val($sformatf("op%0d_flags", i + 2), {tbl_c[i], 1'b0});
      alu(3'(i + 2));
      check_out(o_flags);
      i_alu_dst = 1'b1;
      expect_val($sformatf("op%0d_r", i + 2), tbl_r[i]);
      do_cmd(4'hA);
      do_cmd(4'h6);
      check_out(o_mem_addr);
    end
    i_alu_dst = 1'b0;

    // Write with a long stall; PC increments must be ignored while busy
    mem_read(8'h77);
    expect_val("wr_wdata", 8'h77);
    expect_val("wr_we", 1);
    expect_val("wr_req", 1);
    do_cmd(4'h9);
    check_out(o_mem_wdata);
    check_out(o_mem_we);
    check_out(o_mem_req);
    expect_val("wr_stall_busy", 1);
    i_inc_pc = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    i_inc_pc = 1'b0;
    check_out(o_busy);
    expect_val("wr_done_busy", 0);
    i_mem_ack = 1'b1;
    cyc();
    i_mem_ack = 1'b0;
    check_out(o_busy);
    expect_val("wr_pc_held", 8'h41);
    do_cmd(4'h1);
    check_out(o_mem_addr);

    // Reset in the middle of a write; a late ack is ignored
    do_cmd(4'h9);
    cyc();
    expect_val("mid_req", 1);
    check_out(o_mem_req);
    expect_val("async_rst_req", 0);
    expect_val("async_rst_busy", 0);
    #2 i_rstn = 1'b0;
    #1;
    check_out(o_mem_req);
    check_out(o_busy);
    @(negedge i_clk);
    i_rstn = 1'b1;
    i_mem_ack = 1'b1;
    cyc();
    i_mem_ack = 1'b0;
    expect_val("late_ack_busy", 0);
    expect_val("late_ack_req", 0);
    check_out(o_busy);
    check_out(o_mem_req);

    // SP limits from SP_INIT = 0xFF
    i_inc_dec_sp = 2'b01;
    cyc();
    i_inc_dec_sp = 2'b00;
    expect_val("sp_inc", SpAfterInc);
    expect_val("sp_inc_fault", SpFault);
    do_cmd(4'h7);
    check_out(o_mem_addr);
    check_out(o_sp_fault);
    i_inc_dec_sp = 2'b10;
    cyc();
    i_inc_dec_sp = 2'b00;
    expect_val("sp_dec", SpAfterDec);
    expect_val("sp_dec_fault", SpFault);
    do_cmd(4'h7);
    check_out(o_mem_addr);
    check_out(o_sp_fault);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
